// File: rtl/sram_port_arb.sv
// Round-robin arbiter sharing one single-port SRAM between NREQ requesters.
// A requester may lock the port across beats. Out-of-range addresses complete
// the handshake without touching the SRAM and raise a sticky error flag.
module sram_port_arb #(
    parameter int unsigned NREQ   = 3,
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ-1:0]        req_lock,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*WIDTH-1:0]  req_wdata,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [WIDTH-1:0]       rsp_rdata,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [WIDTH-1:0]       mem_din,
    input  logic [WIDTH-1:0]       mem_dout,
    output logic                   err_oob
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [0:0] {StArb, StLocked} state_e;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]  owner_q, owner_d;
    logic [NREQ-1:0]   rd_pend_q, rd_pend_d;
    logic              oob_pend_q, oob_pend_d;
    logic              err_oob_q, err_oob_d;

    logic              beat;
    logic [PTR_W-1:0]  gnt_idx;
    logic [PTR_W-1:0]  cand_idx;
    logic [NREQ-1:0]   gnt;
    logic [ADDR_W-1:0] gnt_addr;
    logic [WIDTH-1:0]  gnt_wdata;
    logic              gnt_we;
    logic              gnt_lock;
    logic              gnt_oob;

    // Grant selection: owner only while locked, else first valid from rr_ptr upward.
    always_comb begin
        beat     = 1'b0;
        gnt_idx  = '0;
        cand_idx = '0;
        gnt      = '0;
        if (rst_n) begin
            if (state_q == StLocked) begin
                if (req_valid[owner_q]) begin
                    beat    = 1'b1;
                    gnt_idx = owner_q;
                end
            end else begin
                for (int unsigned k = 0; k < NREQ; k++) begin
                    cand_idx = PTR_W'((32'(rr_ptr_q) + k) % NREQ);
                    if (!beat && req_valid[cand_idx]) begin
                        beat    = 1'b1;
                        gnt_idx = cand_idx;
                    end
                end
            end
        end
        gnt[gnt_idx] = beat;
    end

    // Granted requester's fields and SRAM port drive; out-of-range beats never reach the SRAM.
    always_comb begin
        gnt_addr  = req_addr[gnt_idx*ADDR_W +: ADDR_W];
        gnt_wdata = req_wdata[gnt_idx*WIDTH +: WIDTH];
        gnt_we    = req_we[gnt_idx];
        gnt_lock  = req_lock[gnt_idx];
        gnt_oob   = beat && (32'(gnt_addr) >= DEPTH);
        req_ready = gnt;
        mem_en    = beat && !gnt_oob;
        mem_we    = beat && !gnt_oob && gnt_we;
        mem_addr  = gnt_addr;
        mem_din   = gnt_wdata;
    end

    // Next-state: pointer advance, lock FSM, read-response tracking, sticky error.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        rd_pend_d  = '0;
        oob_pend_d = 1'b0;
        err_oob_d  = err_oob_q | gnt_oob;
        if (beat) begin
            rr_ptr_d = (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
            if (!gnt_we) begin
                rd_pend_d  = gnt;
                oob_pend_d = gnt_oob;
            end
            case (state_q)
                StArb: begin
                    if (gnt_lock) begin
                        state_d = StLocked;
                        owner_d = gnt_idx;
                    end
                end
                StLocked: begin
                    if (!gnt_lock) begin
                        state_d = StArb;
                    end
                end
                default: state_d = StArb;
            endcase
        end
    end

    // State registers; reset drops ownership and any outstanding response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StArb;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            rd_pend_q  <= '0;
            oob_pend_q <= 1'b0;
            err_oob_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            rd_pend_q  <= rd_pend_d;
            oob_pend_q <= oob_pend_d;
            err_oob_q  <= err_oob_d;
        end
    end

    // Response outputs: SRAM data arrives the cycle after the read beat; out-of-range reads return 0.
    always_comb begin
        rsp_valid = rd_pend_q;
        rsp_rdata = (|rd_pend_q && !oob_pend_q) ? mem_dout : '0;
        err_oob   = err_oob_q;
    end

endmodule

// File: tb/tb_sram_port_arb.sv
// Bench for sram_port_arb: directed scenarios plus a randomized phase, all
// checked against a behavioural model of the arbitration and memory rules.
module tb_sram_port_arb;

    localparam int NREQ   = 3;
    localparam int DEPTH  = 3000;
    localparam int WIDTH  = 8;
    localparam int ADDR_W = 12;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        req_we;
    logic [NREQ-1:0]        req_lock;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*WIDTH-1:0]  req_wdata;
    logic [NREQ-1:0]        rsp_valid;
    logic [WIDTH-1:0]       rsp_rdata;
    logic                   mem_en;
    logic                   mem_we;
    logic [ADDR_W-1:0]      mem_addr;
    logic [WIDTH-1:0]       mem_din;
    logic [WIDTH-1:0]       mem_dout;
    logic                   err_oob;

    sram_port_arb #(
        .NREQ   (NREQ),
        .DEPTH  (DEPTH),
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .err_oob   (err_oob)
    );

    always #5 clk = ~clk;

    // External SRAM the arbiter drives (environment, not the reference model).
    bit [WIDTH-1:0] sram [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_din;
            else        mem_dout <= sram[mem_addr];
        end
    end

    // Reference model state.
    bit [WIDTH-1:0] model_mem [0:DEPTH-1];
    int             m_ptr;
    bit             m_locked;
    int             m_owner;
    bit             m_err;
    logic [NREQ-1:0] m_rsp_vec;
    logic [WIDTH-1:0] m_rsp_data;

    int n_checks = 0;
    int n_pass   = 0;

    // DUT observations from the most recent cycle.
    logic [NREQ-1:0]  last_ready;
    logic             last_mem_en;
    logic [NREQ-1:0]  last_rsp_valid;
    logic [WIDTH-1:0] last_rdata;
    logic             last_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int get_addr(input int i);
        return int'(req_addr[i*ADDR_W +: ADDR_W]);
    endfunction

    function automatic int get_wdata(input int i);
        return int'(req_wdata[i*WIDTH +: WIDTH]);
    endfunction

    // Who should be granted now, from the rules: owner only when locked, else round robin.
    function automatic int exp_grant();
        if (m_locked) return req_valid[m_owner] ? m_owner : -1;
        for (int k = 0; k < NREQ; k++) begin
            if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input bit v, input bit we, input bit lk,
                           input int a, input int d);
        req_valid[i] = v;
        req_we[i]    = we;
        req_lock[i]  = lk;
        req_addr[i*ADDR_W +: ADDR_W] = a[ADDR_W-1:0];
        req_wdata[i*WIDTH +: WIDTH]  = d[WIDTH-1:0];
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NREQ; i++) set_req(i, 0, 0, 0, 0, 0);
    endtask

    // One clock: compare everything at the falling edge, then advance the model at the rising edge.
    task automatic cycle();
        int g;
        int a;
        bit oob;
        logic [NREQ-1:0] ev;
        @(negedge clk);
        g  = exp_grant();
        ev = '0;
        if (g >= 0) ev[g] = 1'b1;
        a   = (g >= 0) ? get_addr(g) : 0;
        oob = (g >= 0) && (a >= DEPTH);
        check("req_ready", req_ready, ev);
        check("mem_en", mem_en, (g >= 0 && !oob));
        check("mem_we", mem_we, (g >= 0 && !oob && req_we[g]));
        if (g >= 0 && !oob) check("mem_addr", mem_addr, a);
        if (g >= 0 && !oob && req_we[g]) check("mem_din", mem_din, get_wdata(g));
        check("rsp_valid", rsp_valid, m_rsp_vec);
        check("rsp_rdata", rsp_rdata, m_rsp_data);
        check("err_oob", err_oob, m_err);
        last_ready     = req_ready;
        last_mem_en    = mem_en;
        last_rsp_valid = rsp_valid;
        last_rdata     = rsp_rdata;
        last_err       = err_oob;
        @(posedge clk);
        m_rsp_vec  = '0;
        m_rsp_data = '0;
        if (g >= 0) begin
            m_ptr = (g + 1) % NREQ;
            if (oob) m_err = 1'b1;
            if (req_we[g]) begin
                if (!oob) model_mem[a] = get_wdata(g);
            end else begin
                m_rsp_vec  = ev;
                m_rsp_data = oob ? '0 : model_mem[a];
            end
            if (!m_locked && req_lock[g]) begin
                m_locked = 1'b1;
                m_owner  = g;
            end else if (m_locked && !req_lock[g]) begin
                m_locked = 1'b0;
            end
        end
        #1;
    endtask

    // Asynchronous reset pulse spanning one rising edge; outputs must be quiet throughout.
    task automatic apply_reset();
        rst_n      = 1'b0;
        m_ptr      = 0;
        m_locked   = 1'b0;
        m_owner    = 0;
        m_err      = 1'b0;
        m_rsp_vec  = '0;
        m_rsp_data = '0;
        #2;
        check("rst_req_ready", req_ready, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_err_oob", err_oob, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int order[6];
        rst_n = 1'b1;
        clear_reqs();
        #1;
        apply_reset();

        // Prime SRAM words 1..3 with known data.
        for (int k = 1; k <= 3; k++) begin
            set_req(0, 1, 1, 0, k, 8'h40 + k);
            cycle();
        end

        // Three continuous readers from reset: grants 0,1,2,0,1,2 with responses one cycle later.
        for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, 0, i + 1, 0);
        apply_reset();
        order = '{0, 1, 2, 0, 1, 2};
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("rr_order", last_ready, 1 << order[k]);
        end

        // Write 0xA5 to address 10 by requester 1, then read it back by requester 0.
        clear_reqs();
        set_req(1, 1, 1, 0, 10, 8'hA5);
        cycle();
        clear_reqs();
        set_req(0, 1, 0, 0, 10, 0);
        cycle();
        clear_reqs();
        cycle();
        check("raw_rsp_valid", last_rsp_valid, 3'b001);
        check("raw_rdata", last_rdata, 8'hA5);

        // Requester 2 locks for four beats while 0 and 1 wait, then 0 wins.
        set_req(2, 1, 0, 1, 2, 0);
        cycle();
        check("lock_grant0", last_ready, 3'b100);
        set_req(0, 1, 0, 0, 1, 0);
        set_req(1, 1, 0, 0, 2, 0);
        cycle();
        check("lock_grant1", last_ready, 3'b100);
        cycle();
        check("lock_grant2", last_ready, 3'b100);
        set_req(2, 1, 0, 0, 3, 0);
        cycle();
        check("lock_grant3", last_ready, 3'b100);
        set_req(2, 0, 0, 0, 0, 0);
        cycle();
        check("lock_release", last_ready, 3'b001);

        // Owner goes idle for three cycles while locked: nothing granted, then ownership resumes.
        clear_reqs();
        set_req(2, 1, 0, 1, 5, 0);
        cycle();
        check("stall_lock", last_ready, 3'b100);
        set_req(2, 0, 0, 1, 5, 0);
        set_req(0, 1, 0, 0, 1, 0);
        set_req(1, 1, 1, 0, 7, 8'h3C);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("stall_ready", last_ready, 0);
            check("stall_mem_en", last_mem_en, 0);
        end
        set_req(2, 1, 0, 0, 5, 0);
        cycle();
        check("stall_resume", last_ready, 3'b100);
        set_req(2, 0, 0, 0, 0, 0);
        cycle();
        check("stall_after", last_ready, 3'b001);

        // Out-of-range read: handshake completes, SRAM untouched, zero data, sticky error.
        clear_reqs();
        set_req(0, 1, 0, 0, 3500, 0);
        cycle();
        check("oob_ready", last_ready, 3'b001);
        check("oob_mem_en", last_mem_en, 0);
        clear_reqs();
        cycle();
        check("oob_rsp_valid", last_rsp_valid, 3'b001);
        check("oob_rdata", last_rdata, 0);
        check("oob_err_set", last_err, 1);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("oob_err_sticky", last_err, 1);
        end

        // Reset mid-lock with a read outstanding: no response, round robin restarts at 0.
        set_req(1, 1, 0, 1, 2, 0);
        cycle();
        cycle();
        check("mid_lock_owner", last_ready, 3'b010);
        for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, 0, i, 0);
        apply_reset();
        cycle();
        check("post_rst_grant", last_ready, 3'b001);
        check("post_rst_no_rsp", last_rsp_valid, 0);

        // Randomized traffic on a small address window with occasional out-of-range beats.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                int a;
                a = ($urandom_range(15) == 0) ? int'($urandom_range(4095, DEPTH))
                                              : int'($urandom_range(15));
                set_req(i, $urandom_range(9) < 6, $urandom_range(1) == 1,
                        $urandom_range(3) == 0, a, int'($urandom_range(255)));
            end
            cycle();
        end
        apply_reset();
        clear_reqs();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
